// File: rtl/cpu_io_pkg.sv
// Shared constants and types for the CPU I/O port blocks.
package cpu_io_pkg;

  localparam int DATA_W         = 32;
  localparam int OUT_FIFO_DEPTH = 4;

  typedef logic [DATA_W-1:0] word_t;

endpackage : cpu_io_pkg

// File: rtl/out_fifo_ram.sv
// DEPTH x DATA_W storage for the CPU output-port FIFO.
// One synchronous write port and one asynchronous read port.
module out_fifo_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; the pointers and count decide which entries are valid,
  // so clearing the array would only cost area and reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : out_fifo_ram

// File: rtl/cpu_out_port_fifo.sv
// CPU output-port buffer: captures CPU port writes and drains them over valid/ready.
// Define OUT_FIFO_OVF_EN to enable the sticky overflow flag Ovf; otherwise Ovf is tied to 0.
module cpu_out_port_fifo
  import cpu_io_pkg::*;
#(
  parameter int DATA_W = cpu_io_pkg::DATA_W,
  parameter int DEPTH  = OUT_FIFO_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              Out_Wr,
  input  logic [DATA_W-1:0] Out_Data,
  output logic              Out_Full,
  output logic              Out_Empty,
  output logic              Dev_Valid,
  output logic [DATA_W-1:0] Dev_Data,
  input  logic              Dev_Ready,
  output logic [CNT_W-1:0]  Count,
  output logic              Ovf
);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full, empty, push, pop, wr_en;
  logic [DATA_W-1:0] rd_data;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  // A full FIFO drops the write even when a pop frees a slot this same cycle.
  assign push  = Out_Wr && !full;
  assign pop   = !empty && Dev_Ready;
  assign wr_en = Reset && !Flush && push;

  always_comb begin
    // NOTE: every _d signal gets its hold value first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  out_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_ram (
    .clk     (Clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (Out_Data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

`ifdef OUT_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (Flush)             ovf_d = 1'b0;
    else if (Out_Wr && full) ovf_d = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign Ovf = ovf_q;
`else
  assign Ovf = 1'b0;
`endif

  assign Out_Full  = full;
  assign Out_Empty = empty;
  assign Dev_Valid = !empty;
  assign Dev_Data  = empty ? '0 : rd_data;
  assign Count     = count_q;

endmodule : cpu_out_port_fifo

// File: tb/tb_cpu_out_port_fifo.sv
// Self-checking bench for cpu_out_port_fifo: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_cpu_out_port_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam bit OVF_EN =
`ifdef OUT_FIFO_OVF_EN
    1'b1;
`else
    1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             out_wr = 1'b0;
  logic [31:0]      out_data = '0;
  logic             out_full, out_empty, dev_valid, ovf;
  logic [31:0]      dev_data;
  logic             dev_ready = 1'b0;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queue contents and the sticky overflow flag.
  logic [31:0] mq[$];
  bit          m_ovf = 1'b0;

  always #5 clk = ~clk;

  cpu_out_port_fifo dut (
    .Clock     (clk),
    .Reset     (rst_n),
    .Flush     (flush),
    .Out_Wr    (out_wr),
    .Out_Data  (out_data),
    .Out_Full  (out_full),
    .Out_Empty (out_empty),
    .Dev_Valid (dev_valid),
    .Dev_Data  (dev_data),
    .Dev_Ready (dev_ready),
    .Count     (count),
    .Ovf       (ovf)
  );

  function automatic logic [31:0] m_head();
    return (mq.size() == 0) ? 32'h0 : mq[0];
  endfunction

  // Apply one cycle of inputs, advance the model at the edge, then settle past it.
  task automatic drive_cycle(input bit rst, input bit fl, input bit wr,
                             input logic [31:0] d, input bit rdy);
    bit m_full, do_pop, do_push;
    rst_n = rst; flush = fl; out_wr = wr; out_data = d; dev_ready = rdy;
    @(posedge clk);
    if (!rst || fl) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      m_full  = (mq.size() == DEPTH);
      do_pop  = (mq.size() != 0) && rdy;
      do_push = wr && !m_full;
      if (wr && m_full && OVF_EN) m_ovf = 1'b1;
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    drive_cycle(0, 0, 0, 32'h0, 0);
    drive_cycle(0, 0, 1, 32'h1234_5678, 0);
    drive_cycle(1, 0, 0, 32'h0, 0);
    n_checks++; if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
    n_checks++; if (out_empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", out_empty); else n_pass++;
    n_checks++; if (out_full !== 1'b0) $display("FAIL reset_full: got %b expected 0", out_full); else n_pass++;
    n_checks++; if (dev_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", dev_valid); else n_pass++;
    n_checks++; if (dev_data !== 32'h0) $display("FAIL reset_data: got %h expected 0", dev_data); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf); else n_pass++;
  endtask

  task automatic test_fill_drain();
    logic [31:0] w [4];
    w = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, 0, 1, w[i], 0);
      n_checks++; if (count !== CNT_W'(i + 1)) $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1); else n_pass++;
      n_checks++; if (dev_data !== w[0]) $display("FAIL fill_head[%0d]: got %h expected %h", i, dev_data, w[0]); else n_pass++;
    end
    n_checks++; if (out_full !== 1'b1) $display("FAIL fill_full: got %b expected 1", out_full); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (dev_valid !== 1'b1 || dev_data !== w[i]) $display("FAIL drain_word[%0d]: got %b/%h expected 1/%h", i, dev_valid, dev_data, w[i]); else n_pass++;
      drive_cycle(1, 0, 0, 32'h0, 1);
    end
    n_checks++; if (out_empty !== 1'b1 || count !== 3'd0) $display("FAIL drain_empty: got %b/%0d expected 1/0", out_empty, count); else n_pass++;
  endtask

  task automatic test_full_write_pop();
    logic [31:0] w [4];
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      drive_cycle(1, 0, 1, w[i], 0);
    end
    drive_cycle(1, 0, 1, 32'hDEAD_BEEF, 1);
    n_checks++; if (count !== 3'd3) $display("FAIL fullpop_count: got %0d expected 3", count); else n_pass++;
    n_checks++; if (ovf !== OVF_EN) $display("FAIL fullpop_ovf: got %b expected %b", ovf, OVF_EN); else n_pass++;
    for (int i = 1; i < 4; i++) begin
      n_checks++; if (dev_data !== w[i] || dev_data === 32'hDEAD_BEEF) $display("FAIL fullpop_drain[%0d]: got %h expected %h", i, dev_data, w[i]); else n_pass++;
      drive_cycle(1, 0, 0, 32'h0, 1);
    end
    n_checks++; if (out_empty !== 1'b1 || ovf !== OVF_EN) $display("FAIL fullpop_end: got empty=%b ovf=%b expected 1/%b", out_empty, ovf, OVF_EN); else n_pass++;
  endtask

  task automatic test_steady_stream();
    drive_cycle(1, 0, 1, 32'h100, 0);
    drive_cycle(1, 0, 1, 32'h101, 0);
    n_checks++; if (count !== 3'd2) $display("FAIL stream_start: got %0d expected 2", count); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (dev_data !== 32'h100 + i) $display("FAIL stream_word[%0d]: got %h expected %h", i, dev_data, 32'h100 + i); else n_pass++;
      drive_cycle(1, 0, 1, 32'h102 + i, 1);
      n_checks++; if (count !== 3'd2) $display("FAIL stream_count[%0d]: got %0d expected 2", i, count); else n_pass++;
    end
    for (int i = 10; i < 12; i++) begin
      n_checks++; if (dev_data !== 32'h100 + i) $display("FAIL stream_tail[%0d]: got %h expected %h", i, dev_data, 32'h100 + i); else n_pass++;
      drive_cycle(1, 0, 0, 32'h0, 1);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) drive_cycle(1, 0, 1, 32'h7000 + i, 0);
    drive_cycle(1, 0, 1, 32'hBAD0_0001, 1);
    drive_cycle(1, 0, 0, 32'h0, 0);
    n_checks++; if (count !== 3'd3 || ovf !== OVF_EN) $display("FAIL flush_pre: got %0d/%b expected 3/%b", count, ovf, OVF_EN); else n_pass++;
    drive_cycle(1, 1, 1, 32'hCAFE_F00D, 1);
    n_checks++; if (count !== 3'd0 || ovf !== 1'b0) $display("FAIL flush_clear: got %0d/%b expected 0/0", count, ovf); else n_pass++;
    n_checks++; if (dev_valid !== 1'b0 || dev_data !== 32'h0) $display("FAIL flush_valid: got %b/%h expected 0/0", dev_valid, dev_data); else n_pass++;
    drive_cycle(1, 0, 1, 32'h0000_0005, 0);
    n_checks++; if (dev_data !== 32'h5 || count !== 3'd1) $display("FAIL flush_next: got %h/%0d expected 5/1", dev_data, count); else n_pass++;
    drive_cycle(1, 0, 0, 32'h0, 1);
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 4; i++) drive_cycle(1, 0, 1, 32'h9000 + i, 0);
    drive_cycle(1, 0, 0, 32'h0, 1);
    n_checks++; if (count !== 3'd3 || dev_data !== 32'h9001) $display("FAIL rstmid_pre: got %0d/%h expected 3/9001", count, dev_data); else n_pass++;
    drive_cycle(0, 0, 0, 32'h0, 1);
    n_checks++; if (count !== 3'd0 || out_empty !== 1'b1 || out_full !== 1'b0) $display("FAIL rstmid_state: got %0d/%b/%b expected 0/1/0", count, out_empty, out_full); else n_pass++;
    n_checks++; if (dev_valid !== 1'b0 || dev_data !== 32'h0 || ovf !== 1'b0) $display("FAIL rstmid_out: got %b/%h/%b expected 0/0/0", dev_valid, dev_data, ovf); else n_pass++;
    drive_cycle(1, 0, 1, 32'hA5A5_A5A5, 0);
    n_checks++; if (dev_data !== 32'hA5A5_A5A5 || count !== 3'd1) $display("FAIL rstmid_first: got %h/%0d expected a5a5a5a5/1", dev_data, count); else n_pass++;
    drive_cycle(1, 0, 0, 32'h0, 1);
  endtask

  task automatic test_random();
    bit wr, rdy, fl;
    for (int i = 0; i < 400; i++) begin
      wr  = ($urandom_range(99) < 60);
      rdy = ($urandom_range(99) < 45);
      fl  = ($urandom_range(99) < 4);
      drive_cycle(1, fl, wr, $urandom, rdy);
      n_checks++; if (count !== CNT_W'(mq.size())) $display("FAIL rand_count[%0d]: got %0d expected %0d", i, count, mq.size()); else n_pass++;
      n_checks++; if (out_full !== (mq.size() == DEPTH) || out_empty !== (mq.size() == 0)) $display("FAIL rand_flags[%0d]: got full=%b empty=%b expected size %0d", i, out_full, out_empty, mq.size()); else n_pass++;
      n_checks++; if (dev_valid !== (mq.size() != 0) || dev_data !== m_head()) $display("FAIL rand_head[%0d]: got %b/%h expected %h", i, dev_valid, dev_data, m_head()); else n_pass++;
      n_checks++; if (ovf !== m_ovf) $display("FAIL rand_ovf[%0d]: got %b expected %b", i, ovf, m_ovf); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_write_pop();
    drive_cycle(0, 0, 0, 32'h0, 0);
    test_steady_stream();
    test_flush();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_cpu_out_port_fifo
